spi_target_obi_bridge: RTL

//  SPI target (mode 0, single-lane) that lets an external host read and write the OBI bus. It sits

---
 rtl/spi_target_obi_bridge.sv | 391 +++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_target_obi_bridge.sv
// SPI mode-0 target that gives an external host auto-incrementing word-burst
// read/write access to the OBI bus through a single-outstanding OBI manager port.
module spi_target_obi_bridge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_INC    = 4,
  parameter logic [31:0] RD_FILL     = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        spi_csb_i,
  input  logic        spi_sck_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic        spi_miso_oe_o,
  output logic        obi_req_o,
  input  logic        obi_gnt_i,
  output logic [31:0] obi_addr_o,
  output logic        obi_we_o,
  output logic [3:0]  obi_be_o,
  output logic [31:0] obi_wdata_o,
  input  logic        obi_rvalid_i,
  input  logic [31:0] obi_rdata_i,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned CNT_W     = 5;
  localparam logic [CNT_W-1:0] LAST_BYTE_BIT = CNT_W'(7);
  localparam logic [CNT_W-1:0] LAST_WORD_BIT = CNT_W'(31);
  localparam logic [7:0]  CMD_WRITE = 8'h02;
  localparam logic [7:0]  CMD_READ  = 8'h03;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, WDATA, RDUMMY, RDATA, IGNORE
  } spi_state_e;

  typedef enum logic [1:0] {
    O_IDLE, O_REQ, O_RSP
  } obi_state_e;

  // synchronizer / edge-detect state
  logic [SYNC_STAGES-1:0] csb_sync_q, csb_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   csb_prev_q, csb_prev_d;
  logic                   sck_prev_q, sck_prev_d;

  // SPI side state
  spi_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      sh_q, sh_d;
  logic [31:0]      tx_q, tx_d;
  logic [31:0]      addr_q, addr_d;
  logic             rd_mode_q, rd_mode_d;
  logic             miso_q, miso_d;
  logic             miso_oe_q, miso_oe_d;
  logic             err_q, err_d;

  // OBI side state
  obi_state_e       o_state_q, o_state_d;
  logic             req_q, req_d;
  logic [31:0]      obi_addr_q, obi_addr_d;
  logic             we_q, we_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rbuf_q, rbuf_d;
  logic             rbuf_valid_q, rbuf_valid_d;
  logic             rd_pend_q, rd_pend_d;
  logic [31:0]      pend_addr_q, pend_addr_d;
  logic             discard_q, discard_d;
  logic             busy_q, busy_d;

  // SPI -> OBI handshake
  logic        csb_s, sck_s, mosi_s;
  logic        csb_fall, csb_rise, sck_rise, sck_fall;
  logic [31:0] sh_next;
  logic        o_free;
  logic        do_load;
  logic        wr_issue;
  logic        rd_issue;
  logic [31:0] rd_issue_addr;
  logic        consume;
  logic        fill_used;

  assign csb_s    = csb_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign csb_fall = csb_prev_q & ~csb_s;
  assign csb_rise = ~csb_prev_q & csb_s;
  assign sck_rise = ~sck_prev_q & sck_s;
  assign sck_fall = sck_prev_q & ~sck_s;
  assign sh_next  = {sh_q[30:0], mosi_s};
  assign o_free   = (o_state_q == O_IDLE) && !rd_pend_q;

  // Shift the asynchronous pad inputs through the synchronizer chains
  always_comb begin
    csb_sync_d  = {csb_sync_q[SYNC_STAGES-2:0], spi_csb_i};
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
    csb_prev_d  = csb_s;
    sck_prev_d  = sck_s;
  end

  // SPI frame FSM: field decode, address tracking, shift in/out
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sh_d          = sh_q;
    tx_d          = tx_q;
    addr_d        = addr_q;
    rd_mode_d     = rd_mode_q;
    miso_d        = miso_q;
    miso_oe_d     = miso_oe_q;
    err_d         = err_q;
    do_load       = 1'b0;
    wr_issue      = 1'b0;
    rd_issue      = 1'b0;
    rd_issue_addr = addr_q;
    consume       = 1'b0;
    fill_used     = 1'b0;

    if (csb_rise) begin
      state_d   = IDLE;
      cnt_d     = '0;
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
    end else if (csb_fall) begin
      state_d   = CMD;
      cnt_d     = '0;
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
      err_d     = 1'b0;
    end else begin
      case (state_q)
        CMD: begin
          if (sck_rise) begin
            sh_d = sh_next;
            if (cnt_q == LAST_BYTE_BIT) begin
              cnt_d = '0;
              if (sh_next[7:0] == CMD_WRITE) begin
                state_d   = ADDR;
                rd_mode_d = 1'b0;
              end else if (sh_next[7:0] == CMD_READ) begin
                state_d   = ADDR;
                rd_mode_d = 1'b1;
              end else begin
                state_d = IGNORE;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ADDR: begin
          if (sck_rise) begin
            sh_d = sh_next;
            if (cnt_q == LAST_WORD_BIT) begin
              cnt_d  = '0;
              addr_d = {sh_next[31:2], 2'b00};
              if (rd_mode_q) begin
                state_d       = RDUMMY;
                rd_issue      = 1'b1;
                rd_issue_addr = {sh_next[31:2], 2'b00};
              end else begin
                state_d = WDATA;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        WDATA: begin
          if (sck_rise) begin
            sh_d = sh_next;
            if (cnt_q == LAST_WORD_BIT) begin
              cnt_d = '0;
              // a word arriving while the previous write is still open is dropped
              if (o_free) begin
                wr_issue = 1'b1;
                addr_d   = addr_q + 32'(ADDR_INC);
              end else begin
                err_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        RDUMMY: begin
          if (sck_rise) begin
            if (cnt_q == LAST_BYTE_BIT) begin
              do_load = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        RDATA: begin
          if (sck_rise) begin
            if (cnt_q == LAST_WORD_BIT) begin
              do_load = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (sck_fall && (cnt_q != '0)) begin
            // the fall right after a load is skipped so bit31 is held for the host
            tx_d   = {tx_q[30:0], 1'b0};
            miso_d = tx_q[30];
          end
        end
        default: ;
      endcase

      // word load: buffered prefetch or fill pattern, then prefetch the next word
      if (do_load) begin
        if (rbuf_valid_q) begin
          tx_d    = rbuf_q;
          consume = 1'b1;
        end else begin
          tx_d      = RD_FILL;
          err_d     = 1'b1;
          fill_used = 1'b1;
        end
        miso_d        = tx_d[31];
        miso_oe_d     = 1'b1;
        addr_d        = addr_q + 32'(ADDR_INC);
        rd_issue      = 1'b1;
        rd_issue_addr = addr_q + 32'(ADDR_INC);
        cnt_d         = '0;
        state_d       = RDATA;
      end
    end
  end

  // OBI manager FSM with one-word read buffer and pending-read slot
  always_comb begin
    o_state_d    = o_state_q;
    req_d        = req_q;
    obi_addr_d   = obi_addr_q;
    we_d         = we_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    rbuf_d       = rbuf_q;
    rbuf_valid_d = rbuf_valid_q;
    rd_pend_d    = rd_pend_q;
    pend_addr_d  = pend_addr_q;
    discard_d    = discard_q;

    if (consume || csb_fall) begin
      rbuf_valid_d = 1'b0;
    end
    // an in-flight read whose data can no longer be used must not land in the buffer
    if ((csb_rise || fill_used) && (o_state_q != O_IDLE)) begin
      discard_d = 1'b1;
    end

    case (o_state_q)
      O_IDLE: begin
        if (wr_issue) begin
          o_state_d  = O_REQ;
          req_d      = 1'b1;
          obi_addr_d = addr_q;
          we_d       = 1'b1;
          be_d       = 4'hF;
          wdata_d    = sh_next;
        end else if (rd_pend_q && !csb_rise) begin
          o_state_d  = O_REQ;
          req_d      = 1'b1;
          obi_addr_d = pend_addr_q;
          we_d       = 1'b0;
          be_d       = 4'hF;
          rd_pend_d  = 1'b0;
        end
      end
      O_REQ: begin
        if (obi_gnt_i) begin
          o_state_d = O_RSP;
          req_d     = 1'b0;
        end
      end
      O_RSP: begin
        if (obi_rvalid_i) begin
          o_state_d = O_IDLE;
          discard_d = 1'b0;
          if (!we_q && !discard_q && !csb_rise && !fill_used) begin
            rbuf_d       = obi_rdata_i;
            rbuf_valid_d = 1'b1;
          end
        end
      end
      default: o_state_d = O_IDLE;
    endcase

    if (rd_issue) begin
      rd_pend_d   = 1'b1;
      pend_addr_d = rd_issue_addr;
    end
    if (csb_rise) begin
      rd_pend_d = 1'b0;
    end
  end

  // Busy covers an open frame and any OBI work still owed
  always_comb begin
    busy_d = (state_d != IDLE) || (o_state_d != O_IDLE) || rd_pend_d;
  end

  // Synchronizer registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      csb_sync_q  <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      csb_prev_q  <= 1'b1;
      sck_prev_q  <= 1'b0;
    end else begin
      csb_sync_q  <= csb_sync_d;
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      csb_prev_q  <= csb_prev_d;
      sck_prev_q  <= sck_prev_d;
    end
  end

  // SPI frame registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      rd_mode_q <= 1'b0;
      miso_q    <= 1'b0;
      miso_oe_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      rd_mode_q <= rd_mode_d;
      miso_q    <= miso_d;
      miso_oe_q <= miso_oe_d;
      err_q     <= err_d;
    end
  end

  // OBI registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      o_state_q    <= O_IDLE;
      req_q        <= 1'b0;
      obi_addr_q   <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      rbuf_q       <= '0;
      rbuf_valid_q <= 1'b0;
      rd_pend_q    <= 1'b0;
      pend_addr_q  <= '0;
      discard_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      o_state_q    <= o_state_d;
      req_q        <= req_d;
      obi_addr_q   <= obi_addr_d;
      we_q         <= we_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      rbuf_q       <= rbuf_d;
      rbuf_valid_q <= rbuf_valid_d;
      rd_pend_q    <= rd_pend_d;
      pend_addr_q  <= pend_addr_d;
      discard_q    <= discard_d;
      busy_q       <= busy_d;
    end
  end

  assign spi_miso_o    = miso_q;
  assign spi_miso_oe_o = miso_oe_q;
  assign obi_req_o     = req_q;
  assign obi_addr_o    = obi_addr_q;
  assign obi_we_o      = we_q;
  assign obi_be_o      = be_q;
  assign obi_wdata_o   = wdata_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;

endmodule
